ivl_uvm_ovl_win_stim_gen: RTL and testbench
===========================================

Name: ivl_uvm_ovl_win_stim_gen

Overview:
- Stimulus-side counterpart of the ovl_win_change checker.
- Accepts one window command at a time and drives start_event / test_expr / end_event with programmable timing.
- Produces a cycle-accurate exp_fire prediction so the bench can compare it against the checker's fire output.
- Sits in the OVL test harness between the bench control task and the checker under test.

Parameters:
- WIDTH, 4, width of test_expr and cmd_data
- CNT_W, 8, width of the delay/length counters and command fields

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  gates command acceptance only
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high
- cmd_win_len  input  CNT_W  number of open-window cycles between start_event and end_event
- cmd_change_dly  input  CNT_W  window cycle (1-based) in which test_expr is updated
- cmd_data  input  WIDTH  value driven onto test_expr at the change point
- cmd_no_change  input  1  suppress the change (injects a violation)
- start_event  output  1  one-cycle window-open pulse
- end_event  output  1  one-cycle window-close pulse
- test_expr  output  WIDTH  monitored expression
- busy  output  1  high while a command is in flight
- done  output  1  one-cycle completion pulse
- exp_fire  output  1  predicted checker fire

Behaviour:
- Reset (async, reset=0): state IDLE; start_event, end_event, busy, done, exp_fire = 0; test_expr = 0; counters = 0. Reset mid-window aborts the command with no done pulse.
- cmd_ready = (state==IDLE) & enable & reset. All command fields are latched on the accept edge.
- The FSM has five states: IDLE, START, WIN, END, FIN.
- IDLE -> START on accept. busy rises the cycle after accept.
- START (1 cycle): start_event=1. Window counter wcnt is loaded with 1. Go to WIN.
- WIN (eff_len cycles): eff_len = max(cmd_win_len, 1). wcnt increments each cycle.
  - The change is applied when wcnt==cmd_change_dly, cmd_no_change==0 and 1<=cmd_change_dly<=eff_len. On that edge test_expr <= cmd_data.
  - When wcnt==eff_len, go to END.
- END (1 cycle): end_event=1. Go to FIN.
- FIN (1 cycle): done=1, busy=0 on exit. Go to IDLE.
- Change flag chg is set only if the applied cmd_data differs from the prior test_expr. Writing an equal value is not a change.
- exp_fire = 1 for exactly one cycle, registered in the FIN cycle (one cycle after end_event), iff chg==0. chg clears on entry to START.
- Out-of-range cmd_change_dly (0 or > eff_len): no change is applied and exp_fire is predicted.
- Command latency: accept -> start_event 1 cycle; start_event -> end_event eff_len+1 cycles; end_event -> done 1 cycle.
- enable low does not pause an in-flight command. It only blocks acceptance.
- start_event and end_event are never high in the same cycle.
- test_expr holds its value between commands.
- Counters saturate at 2^CNT_W-1. They cannot wrap, because eff_len <= 2^CNT_W-1.

Optional Feature:
- Macro: IVL_UVM_WSG_POSTCHANGE_EN.
- Defined: in the FIN cycle, test_expr <= ~test_expr. This is an out-of-window change that the checker must ignore; exp_fire is unaffected.
- Undefined: test_expr is unchanged after END.

Decomposition:
- Package ivl_uvm_ovl_win_pkg holds:
  - the state enum wsg_state_e {IDLE, START, WIN, END, FIN};
  - the packed struct wsg_cmd_t {win_len, change_dly, data, no_change}, parameterised via localparams with default widths 8/4;
  - the constant WSG_MIN_WIN = 1.
- No sub-module. A single FSM plus counter is natural.

Test Plan:
- Reset held 3 cycles with cmd_valid=1 -> cmd_ready=0; start_event=0, end_event=0; test_expr=0; exp_fire=0.
- test_expr=4'h5, then cmd{win_len=4, change_dly=2, data=4'hA} -> start_event 1 cycle after accept; test_expr=A in window cycle 2; end_event 5 cycles after start_event; exp_fire=0; done 1 cycle after end_event.
- cmd{win_len=3, no_change=1} -> test_expr unchanged; exp_fire=1 in the cycle after end_event.
- test_expr=4'hA, cmd{data=4'hA, change_dly=1, win_len=2} -> equal value, so exp_fire=1.
- cmd{win_len=0, change_dly=1, data=4'h3} -> treated as win_len=1; change applied; end_event 2 cycles after start_event; exp_fire=0. A separate cmd{change_dly=9, win_len=4} -> no change, exp_fire=1.
- Assert reset mid-WIN -> all outputs 0 immediately, no done. With IVL_UVM_WSG_POSTCHANGE_EN defined, test_expr inverts in the FIN cycle, and the checker's fire must still match exp_fire.

Source files
------------

// File: rtl/ivl_uvm_ovl_win_pkg.sv
// Shared types for the OVL window-change stimulus generator.
// State encoding, command bundle and window limits.
package ivl_uvm_ovl_win_pkg;

  localparam int WSG_CNT_W   = 8;
  localparam int WSG_DATA_W  = 4;
  localparam int WSG_MIN_WIN = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WIN,
    END,
    FIN
  } wsg_state_e;

  typedef struct packed {
    logic [WSG_CNT_W-1:0]  win_len;
    logic [WSG_CNT_W-1:0]  change_dly;
    logic [WSG_DATA_W-1:0] data;
    logic                  no_change;
  } wsg_cmd_t;

endpackage

// File: rtl/ivl_uvm_ovl_win_stim_gen.sv
// Window stimulus generator with exp_fire prediction for ovl_win_change.
// Optional IVL_UVM_WSG_POSTCHANGE_EN: invert test_expr after the window.
module ivl_uvm_ovl_win_stim_gen
  import ivl_uvm_ovl_win_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_win_len,
  input  logic [CNT_W-1:0] cmd_change_dly,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_no_change,
  output logic             start_event,
  output logic             end_event,
  output logic [WIDTH-1:0] test_expr,
  output logic             busy,
  output logic             done,
  output logic             exp_fire
);

  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(WSG_MIN_WIN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wsg_state_e       state;
  wsg_state_e       nxt;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] dly_q;
  logic [WIDTH-1:0] data_q;
  logic             noc_q;
  logic [WIDTH-1:0] expr_q;
  logic             chg;
  logic             fire_q;
  logic             accept;
  logic             apply;

  assign cmd_ready = (state == IDLE) & enable & reset;
  assign accept    = cmd_valid & cmd_ready;

  assign apply = (state == WIN) && (wcnt == dly_q) && !noc_q
              && (dly_q >= MIN_LEN) && (dly_q <= len_q);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (accept) nxt = START;
      START: nxt = WIN;
      WIN:   if (wcnt == len_q) nxt = END;
      END:   nxt = FIN;
      FIN:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      wcnt   <= '0;
      len_q  <= '0;
      dly_q  <= '0;
      data_q <= '0;
      noc_q  <= 1'b0;
      expr_q <= '0;
      chg    <= 1'b0;
      fire_q <= 1'b0;
    end else begin
      state  <= nxt;
      fire_q <= (state == END) && !chg;
      if (accept) begin
        len_q  <= (cmd_win_len < MIN_LEN) ? MIN_LEN : cmd_win_len;
        dly_q  <= cmd_change_dly;
        data_q <= cmd_data;
        noc_q  <= cmd_no_change;
        chg    <= 1'b0;
      end else if (apply && (data_q != expr_q)) begin
        chg <= 1'b1;
      end
      if (state == START)
        wcnt <= MIN_LEN;
      else if (state == WIN && wcnt != CNT_MAX)
        wcnt <= wcnt + 1'b1;
      if (apply)
        expr_q <= data_q;
`ifdef IVL_UVM_WSG_POSTCHANGE_EN
      else if (state == FIN)
        expr_q <= ~expr_q;
`endif
    end
  end

  assign start_event = (state == START);
  assign end_event   = (state == END);
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);
  assign test_expr   = expr_q;
  assign exp_fire    = fire_q;

endmodule

// File: tb/tb_ivl_uvm_ovl_win_stim_gen.sv
// Randomized bench for ivl_uvm_ovl_win_stim_gen.
// Expected traces come from per-command cycle arithmetic.
module tb_ivl_uvm_ovl_win_stim_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_win_len;
  logic [7:0] cmd_change_dly;
  logic [3:0] cmd_data;
  logic       cmd_no_change;
  logic       start_event;
  logic       end_event;
  logic [3:0] test_expr;
  logic       busy;
  logic       done;
  logic       exp_fire;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] te = 4'h0;

  always #5 clk = ~clk;

  ivl_uvm_ovl_win_stim_gen #(.WIDTH(4), .CNT_W(8)) dut (
    .clock          (clk),
    .reset          (rst_n),
    .enable         (enable),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_win_len    (cmd_win_len),
    .cmd_change_dly (cmd_change_dly),
    .cmd_data       (cmd_data),
    .cmd_no_change  (cmd_no_change),
    .start_event    (start_event),
    .end_event      (end_event),
    .test_expr      (test_expr),
    .busy           (busy),
    .done           (done),
    .exp_fire       (exp_fire)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic run_cmd(input int wl, input int dly, input logic [3:0] d,
                         input logic noc, input logic drop_en);
    int eff;
    bit applies;
    bit changed;
    logic [3:0] te_new;
    logic [3:0] te_t;
    eff     = (wl == 0) ? 1 : wl;
    applies = (dly >= 1) && (dly <= eff) && !noc;
    changed = applies && (d != te);
    te_new  = applies ? d : te;
    @(negedge clk);
    chk("ready_idle", cmd_ready, 1);
    cmd_valid      = 1'b1;
    cmd_win_len    = 8'(wl);
    cmd_change_dly = 8'(dly);
    cmd_data       = d;
    cmd_no_change  = noc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = ~d;
    if (drop_en) enable = 1'b0;
    for (int t = 1; t <= eff + 4; t++) begin
      te_t = (applies && t >= dly + 2) ? d : te;
`ifdef IVL_UVM_WSG_POSTCHANGE_EN
      if (t == eff + 4) te_t = ~te_new;
`endif
      chk("start_event", start_event, (t == 1));
      chk("end_event", end_event, (t == eff + 2));
      chk("done", done, (t == eff + 3));
      chk("exp_fire", exp_fire, (t == eff + 3) && !changed);
      chk("busy", busy, (t <= eff + 3));
      chk("test_expr", test_expr, te_t);
      chk("ready", cmd_ready, (t == eff + 4) && enable);
      @(negedge clk);
    end
    te = te_new;
`ifdef IVL_UVM_WSG_POSTCHANGE_EN
    te = ~te_new;
`endif
    enable = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    enable         = 1'b1;
    cmd_valid      = 1'b1;
    cmd_win_len    = 8'd4;
    cmd_change_dly = 8'd2;
    cmd_data       = 4'hF;
    cmd_no_change  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_start", start_event, 0);
      chk("rst_end", end_event, 0);
      chk("rst_expr", test_expr, 0);
      chk("rst_fire", exp_fire, 0);
      chk("rst_busy", busy, 0);
    end
    cmd_valid = 1'b0;
    rst_n     = 1'b1;

    run_cmd(4, 1, 4'h5, 0, 0);
    run_cmd(4, 2, 4'hA, 0, 0);
    run_cmd(3, 1, 4'h7, 1, 0);
    run_cmd(2, 1, te, 0, 0);
    run_cmd(0, 1, ~te, 0, 0);
    run_cmd(4, 9, 4'h3, 0, 0);
    run_cmd(0, 0, 4'hC, 0, 0);
    run_cmd(5, 5, ~te, 0, 1);

    // Acceptance is blocked while enable is low.
    @(negedge clk);
    enable    = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en_ready", cmd_ready, 0);
      chk("en_busy", busy, 0);
    end
    cmd_valid = 1'b0;
    enable    = 1'b1;

    for (int i = 0; i < 40; i++) begin
      run_cmd($urandom_range(0, 12), $urandom_range(0, 14),
              4'($urandom), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 4) == 0));
    end
    run_cmd(255, 255, ~te, 0, 0);

    // Asynchronous abort in the middle of a window.
    @(negedge clk);
    cmd_valid      = 1'b1;
    cmd_win_len    = 8'd10;
    cmd_change_dly = 8'd8;
    cmd_data       = 4'hF;
    cmd_no_change  = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_start", start_event, 0);
    chk("abort_end", end_event, 0);
    chk("abort_expr", test_expr, 0);
    chk("abort_fire", exp_fire, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    chk("abort_done2", done, 0);
    rst_n = 1'b1;
    te    = 4'h0;
    @(negedge clk);
    chk("post_abort_busy", busy, 0);
    run_cmd(3, 2, 4'h9, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
